// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
// UART_RCVR_PARITY_EN selects 8E1/8O1 framing instead of 8N1.
package uart_pkg;
  localparam int UART_DATA_W      = 8;
  localparam int DEFAULT_BAUD_DIV = 54;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_t;
endpackage

// File: rtl/uart_byte_rcvr_if.sv
// Receiver-side signal bundle: serial line in, deframed byte and strobes out, FSM state for observers.
// Handshake: uart_data is valid in any cycle where uart_data_rdy is high; there is no back-pressure.
interface uart_byte_rcvr_if;
  import uart_pkg::*;

  logic                   uart_rx;
  logic [UART_DATA_W-1:0] uart_data;
  logic                   uart_data_rdy;
  logic                   framing_err;
`ifdef UART_RCVR_PARITY_EN
  logic                   parity_err;
`endif
  rx_state_t              rx_state;

`ifdef UART_RCVR_PARITY_EN
  modport master (input uart_rx, output uart_data, uart_data_rdy, framing_err, parity_err, rx_state);
  modport slave  (output uart_rx, input uart_data, uart_data_rdy, framing_err, parity_err, rx_state);
`else
  modport master (input uart_rx, output uart_data, uart_data_rdy, framing_err, rx_state);
  modport slave  (output uart_rx, input uart_data, uart_data_rdy, framing_err, rx_state);
`endif
endinterface

// File: rtl/uart_byte_rcvr_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_byte_rcvr.sv
// Oversampling 8-bit UART receiver, LSB first, mid-bit sampling, one-cycle result strobes.
// Build option: UART_RCVR_PARITY_EN adds a parity bit between data and stop (sense set by PARITY_ODD).
module uart_byte_rcvr
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
`ifdef UART_RCVR_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic             clock,
  input  logic             reset,
  uart_byte_rcvr_if.master bus
);
  localparam int              CNT_W   = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  rx_state_t              state, state_nxt;
  logic                   rx_s;
  logic [CNT_W-1:0]       baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [UART_DATA_W-1:0] data_q;
  logic                   rdy_q, ferr_q;
  logic                   sample, shift_en, load_data, set_ferr;
`ifdef UART_RCVR_PARITY_EN
  logic                   par_bad_q, perr_q, set_perr, par_sample;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.uart_rx),
    .q     (rx_s)
  );

  // The start bit is sampled half a bit after t0; every later sample is one full bit on.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    shift_en  = 1'b0;
    load_data = 1'b0;
    set_ferr  = 1'b0;
`ifdef UART_RCVR_PARITY_EN
    set_perr   = 1'b0;
    par_sample = 1'b0;
`endif
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START: begin
        if (baud_cnt == HALF_M1) begin
          sample    = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == FULL_M1) begin
          sample   = 1'b1;
          shift_en = 1'b1;
`ifdef UART_RCVR_PARITY_EN
          if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
          if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RCVR_PARITY_EN
      PARITY: begin
        if (baud_cnt == FULL_M1) begin
          sample     = 1'b1;
          par_sample = 1'b1;
          state_nxt  = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_cnt == FULL_M1) begin
          sample    = 1'b1;
          state_nxt = rx_s ? IDLE : WAIT_HI;
`ifdef UART_RCVR_PARITY_EN
          if (par_bad_q)  set_perr  = 1'b1;
          else if (!rx_s) set_ferr  = 1'b1;
          else            load_data = 1'b1;
`else
          if (!rx_s) set_ferr  = 1'b1;
          else       load_data = 1'b1;
`endif
        end
      end
      WAIT_HI: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      rdy_q  <= load_data;
      ferr_q <= set_ferr;
      if (state == IDLE || sample || baud_cnt == FULL_M1) baud_cnt <= '0;
      else                                                baud_cnt <= baud_cnt + CNT_W'(1);
      if (state == START)  bit_cnt <= '0;
      else if (shift_en)   bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)  shift_reg <= {rx_s, shift_reg[UART_DATA_W-1:1]};
      if (load_data) data_q    <= shift_reg;
`ifdef UART_RCVR_PARITY_EN
      perr_q <= set_perr;
      if (par_sample) par_bad_q <= rx_s ^ (^shift_reg) ^ PARITY_ODD;
`endif
    end
  end

  assign bus.uart_data     = data_q;
  assign bus.uart_data_rdy = rdy_q;
  assign bus.framing_err   = ferr_q;
`ifdef UART_RCVR_PARITY_EN
  assign bus.parity_err    = perr_q;
`endif
  assign bus.rx_state      = state;
endmodule

// File: tb/tb_uart_byte_rcvr.sv
// Bench for uart_byte_rcvr: directed frames plus random byte streams against a frame-level model.
module tb_uart_byte_rcvr;
  import uart_pkg::*;

  localparam int BAUD_DIV   = 54;
  localparam bit PARITY_ODD = 1'b0;
`ifdef UART_RCVR_PARITY_EN
  localparam int STOP_K = 10;
`else
  localparam int STOP_K = 9;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_byte_rcvr_if bus();

`ifdef UART_RCVR_PARITY_EN
  uart_byte_rcvr #(.BAUD_DIV(BAUD_DIV), .PARITY_ODD(PARITY_ODD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`else
  uart_byte_rcvr #(.BAUD_DIV(BAUD_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`endif

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int               checks   = 0;
  int               errors   = 0;
  logic [7:0]       exp_q[$];
  logic [7:0]       last_good = 8'h00;
  logic [7:0]       popped;
  int               exp_ferr = 0, got_ferr = 0;
  int               exp_perr = 0, got_perr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor: every rdy pulse consumes the oldest expected byte
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.uart_data_rdy) begin
        check("rdy_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          check("rx_byte", {24'b0, bus.uart_data}, {24'b0, popped});
        end
      end
      if (bus.framing_err) got_ferr++;
`ifdef UART_RCVR_PARITY_EN
      if (bus.parity_err) got_perr++;
      check("strobe_overlap", {30'b0, bus.uart_data_rdy + bus.framing_err + bus.parity_err > 2'd1}, 32'd0);
`else
      check("strobe_overlap", {31'b0, bus.uart_data_rdy & bus.framing_err}, 32'd0);
`endif
    end
  end

  // driver tasks (all called from a negedge)
  task automatic drive_bit(input logic b, input int cycles);
    bus.uart_rx = b;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic idle_bits(input int n);
    drive_bit(1'b1, n * BAUD_DIV);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_val, input int stop_len,
                           input bit par_flip);
    if (par_flip)      exp_perr++;
    else if (stop_val) begin exp_q.push_back(data); last_good = data; end
    else               exp_ferr++;
    drive_bit(1'b0, BAUD_DIV);
    for (int i = 0; i < 8; i++) drive_bit(data[i], BAUD_DIV);
`ifdef UART_RCVR_PARITY_EN
    drive_bit((^data) ^ PARITY_ODD ^ par_flip, BAUD_DIV);
`endif
    drive_bit(stop_val, stop_len * BAUD_DIV);
    bus.uart_rx = 1'b1;
  endtask

  task automatic check_settled(input string tag);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    check({tag, "_ferr"}, got_ferr, exp_ferr);
    check({tag, "_perr"}, got_perr, exp_perr);
    check({tag, "_data"}, {24'b0, bus.uart_data}, {24'b0, last_good});
  endtask

  int         lat;
  logic [7:0] b, gap, c3;
  logic       bad;

  initial begin
    bus.uart_rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_data", {24'b0, bus.uart_data}, 32'd0);
    check("reset_rdy", {31'b0, bus.uart_data_rdy}, 32'd0);
    check("reset_ferr", {31'b0, bus.framing_err}, 32'd0);
    check("reset_state", 32'(bus.rx_state), 32'(IDLE));
    reset = 1'b0;
    idle_bits(1);

    // single byte with latency measurement from the falling edge on uart_rx
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1, 1, 1'b0);
      begin
        for (int i = 1; i <= 1000; i++) begin
          @(negedge clock);
          if (bus.uart_data_rdy) begin lat = i; break; end
        end
      end
    join
    check("latency", lat, STOP_K * BAUD_DIV + BAUD_DIV / 2 + 1 + 2);
    idle_bits(1);
    check_settled("single");

    // back-to-back with single stop bits
    send_byte(8'h00, 1'b1, 1, 1'b0);
    send_byte(8'hFF, 1'b1, 1, 1'b0);
    send_byte(8'h3C, 1'b1, 1, 1'b0);
    idle_bits(1);
    check_settled("b2b");

    // short low glitch must not start a frame
    drive_bit(1'b0, 10);
    idle_bits(2);
    check("glitch_state", 32'(bus.rx_state), 32'(IDLE));
    check_settled("glitch");
    send_byte(8'h81, 1'b1, 1, 1'b0);
    idle_bits(1);
    check_settled("post_glitch");

    // stop bit held low for three bit times
    send_byte(8'h55, 1'b0, 3, 1'b0);
    idle_bits(2);
    check_settled("framing");
    send_byte(8'h12, 1'b1, 1, 1'b0);
    idle_bits(1);
    check_settled("post_framing");

    // reset during data bit 4 aborts the frame
    c3 = 8'hC3;
    drive_bit(1'b0, BAUD_DIV);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], BAUD_DIV);
    drive_bit(c3[4], 20);
    reset = 1'b1;
    bus.uart_rx = 1'b1;
    @(negedge clock);
    check("midreset_data", {24'b0, bus.uart_data}, 32'd0);
    check("midreset_rdy", {31'b0, bus.uart_data_rdy}, 32'd0);
    check("midreset_ferr", {31'b0, bus.framing_err}, 32'd0);
    check("midreset_state", 32'(bus.rx_state), 32'(IDLE));
    reset = 1'b0;
    last_good = 8'h00;
    idle_bits(2);
    check_settled("midreset");
    send_byte(8'h7E, 1'b1, 1, 1'b0);
    idle_bits(1);
    check_settled("post_reset");

`ifdef UART_RCVR_PARITY_EN
    send_byte(8'h07, 1'b1, 1, 1'b0);
    idle_bits(1);
    check_settled("parity_ok");
    send_byte(8'h07, 1'b1, 1, 1'b1);
    idle_bits(1);
    check_settled("parity_bad");
`endif

    // random stream: mixed gaps, occasional broken stop bits
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      gap = 8'($urandom_range(0, 2));
      if (bad) begin
        send_byte(b, 1'b0, $urandom_range(1, 2), 1'b0);
        idle_bits(int'(gap) + 1);
      end else begin
        send_byte(b, 1'b1, 1, 1'b0);
        if (gap != 0) idle_bits(int'(gap));
      end
    end
    idle_bits(2);
    check_settled("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
